// File: rtl/seg_scan_decoder.sv
// Decoder for a multiplexed 4-digit seven-segment display bus.
// Samples the scanned anode/cathode lines and rebuilds the digit values.
module seg_scan_decoder #(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] an,
   input  logic [7:0] seg,
   output logic [3:0] min10,
   output logic [3:0] min1,
   output logic [3:0] sec10,
   output logic [3:0] sec1,
   output logic [3:0] dp,
   output logic [3:0] digit_err,
   output logic       frame_valid,
   output logic       stale
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
   localparam logic [SW-1:0] STAB_PRE = SW'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] IDLE_PRE = TW'(TIMEOUT_CYCLES - 1);

   logic [3:0]      an_m, an_s;
   logic [7:0]      seg_m, seg_s;
   logic [11:0]     pat_q;
   logic            same;
   logic [SW-1:0]   stab_cnt;
   logic [TW-1:0]   idle_cnt;
   logic [3:0]      seen;
   logic [3:0]      seen_nxt;
   logic            onehot;
   logic [1:0]      sel;
   logic            capture;
   logic [3:0]      dec_val;
   logic            dec_err;
   logic [3:0][3:0] val;

   assign min10 = val[3];
   assign min1  = val[2];
   assign sec10 = val[1];
   assign sec1  = val[0];

   assign same     = ({an_s, seg_s} == pat_q);
   assign capture  = same && onehot && (stab_cnt == STAB_PRE);
   assign seen_nxt = seen | (4'b0001 << sel);

   // Two-flop synchronizer; idle display (all lines high) out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         an_m  <= 4'hF;
         an_s  <= 4'hF;
         seg_m <= 8'hFF;
         seg_s <= 8'hFF;
      end else begin
         an_m  <= an;
         an_s  <= an_m;
         seg_m <= seg;
         seg_s <= seg_m;
      end
   end

   // Stability counter: restart on any pattern change, saturate when settled.
   always_ff @(posedge clk) begin
      if (rst) begin
         pat_q    <= 12'hFFF;
         stab_cnt <= '0;
      end else begin
         pat_q <= {an_s, seg_s};
         if (!same)
            stab_cnt <= '0;
         else if (stab_cnt != STAB_MAX)
            stab_cnt <= stab_cnt + 1'b1;
      end
   end

   // Map a single active-low anode to its digit slot.
   always_comb begin
      onehot = 1'b1;
      sel    = 2'd0;
      case (an_s)
         4'b0111: sel = 2'd3;
         4'b1011: sel = 2'd2;
         4'b1101: sel = 2'd1;
         4'b1110: sel = 2'd0;
         default: onehot = 1'b0;
      endcase
   end

   // Segment pattern (g..a, active low) to digit value.
   always_comb begin
      dec_err = 1'b0;
      dec_val = 4'hE;
      case (seg_s[6:0])
         7'b1000000: dec_val = 4'd0;
         7'b1111001: dec_val = 4'd1;
         7'b0100100: dec_val = 4'd2;
         7'b0110000: dec_val = 4'd3;
         7'b0011001: dec_val = 4'd4;
         7'b0010010: dec_val = 4'd5;
         7'b0000010: dec_val = 4'd6;
         7'b1111000: dec_val = 4'd7;
         7'b0000000: dec_val = 4'd8;
         7'b0010000: dec_val = 4'd9;
         7'b1111111: dec_val = 4'hF;
         default:    dec_err = 1'b1;
      endcase
   end

   // Digit registers: only the captured slot changes.
   always_ff @(posedge clk) begin
      if (rst) begin
         val       <= '0;
         dp        <= '0;
         digit_err <= '0;
      end else if (capture) begin
         val[sel]       <= dec_val;
         dp[sel]        <= ~seg_s[7];
         digit_err[sel] <= dec_err;
      end
   end

   // Frame tracking and idle timeout; a capture wins over a timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         seen        <= '0;
         frame_valid <= 1'b0;
         idle_cnt    <= '0;
         stale       <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         if (capture) begin
            idle_cnt <= '0;
            stale    <= 1'b0;
            if (seen_nxt == 4'hF) begin
               frame_valid <= 1'b1;
               seen        <= '0;
            end else begin
               seen <= seen_nxt;
            end
         end else begin
            if (idle_cnt != IDLE_MAX)
               idle_cnt <= idle_cnt + 1'b1;
            if (idle_cnt >= IDLE_PRE) begin
               stale <= 1'b1;
               seen  <= '0;
            end
         end
      end
   end

endmodule
